// File: rtl/wishbone_to_axi4l_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_to_axi4l_pkg
//   Shared types and constants for the Wishbone-classic to AXI4-Lite bridge.
//   - state_t : bridge FSM states
//   - AXI_RESP_* : AXI4-Lite response codes carried on bresp/rresp
// -----------------------------------------------------------------------------
package wishbone_to_axi4l_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // waiting for a Wishbone strobe
    WRITE = 3'd1,  // AW and W channels in flight
    WRESP = 3'd2,  // waiting for the B response
    RADDR = 3'd3,  // AR channel in flight
    RDATA = 3'd4,  // waiting for the R response
    ACK   = 3'd5   // one-cycle Wishbone completion
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/wishbone_to_axi4l.sv
// -----------------------------------------------------------------------------
// wishbone_to_axi4l
//   Single-clock bridge from a Wishbone classic slave port to an AXI4-Lite
//   master port. One transaction at a time: a Wishbone cycle becomes one
//   AXI4-Lite write (AW+W -> B) or read (AR -> R); the Wishbone ack is issued
//   only after the AXI response has been taken.
//
// Optional feature (macro WISHBONE_TO_AXI4L_ERR_EN):
//   adds s_wb_err_o; a non-OKAY bresp/rresp pulses s_wb_err_o instead of
//   s_wb_ack_o. Without the macro the response codes are discarded.
//
// Ports:
//   m_axi4l_aclk / m_axi4l_aresetn : clock, async active-low reset
//   s_wb_adr_i  : word address (byte address = adr << AXI4L_DATA_SIZE)
//   s_wb_dat_i / s_wb_sel_i / s_wb_we_i / s_wb_stb_i : Wishbone request
//   s_wb_dat_o  : last read data, valid with ack, held until next read
//   s_wb_ack_o  : one-cycle completion pulse
//   s_wb_err_o  : one-cycle error completion (only with the macro)
//   m_axi4l_aw*/w*/b*/ar*/r* : AXI4-Lite master channels
//   o_dbg_state : current FSM state (state_t encoding)
//
// Handshake rule (all AXI channels): a transfer happens on a rising clock edge
// where valid and ready are both high; a valid, once raised, stays high with a
// stable payload until that edge, and is never withdrawn without a transfer.
// -----------------------------------------------------------------------------
module wishbone_to_axi4l
  import wishbone_to_axi4l_pkg::*;
#(
  parameter int         AXI4L_ADDR_BITS = 40,
  parameter int         AXI4L_DATA_SIZE = 3,
  parameter int         AXI4L_DATA_BITS = 8 << AXI4L_DATA_SIZE,
  parameter int         AXI4L_STRB_BITS = AXI4L_DATA_BITS / 8,
  parameter int         WB_ADR_BITS     = AXI4L_ADDR_BITS - AXI4L_DATA_SIZE,
  parameter logic [2:0] AXI4L_PROT      = 3'b000
) (
  input  logic                       m_axi4l_aresetn,
  input  logic                       m_axi4l_aclk,
  // Wishbone classic slave
  input  logic [WB_ADR_BITS-1:0]     s_wb_adr_i,
  input  logic [AXI4L_DATA_BITS-1:0] s_wb_dat_i,
  output logic [AXI4L_DATA_BITS-1:0] s_wb_dat_o,
  input  logic [AXI4L_STRB_BITS-1:0] s_wb_sel_i,
  input  logic                       s_wb_we_i,
  input  logic                       s_wb_stb_i,
  output logic                       s_wb_ack_o,
`ifdef WISHBONE_TO_AXI4L_ERR_EN
  output logic                       s_wb_err_o,
`endif
  // AXI4-Lite write address
  output logic [AXI4L_ADDR_BITS-1:0] m_axi4l_awaddr,
  output logic [2:0]                 m_axi4l_awprot,
  output logic                       m_axi4l_awvalid,
  input  logic                       m_axi4l_awready,
  // AXI4-Lite write data
  output logic [AXI4L_DATA_BITS-1:0] m_axi4l_wdata,
  output logic [AXI4L_STRB_BITS-1:0] m_axi4l_wstrb,
  output logic                       m_axi4l_wvalid,
  input  logic                       m_axi4l_wready,
  // AXI4-Lite write response
  input  logic [1:0]                 m_axi4l_bresp,
  input  logic                       m_axi4l_bvalid,
  output logic                       m_axi4l_bready,
  // AXI4-Lite read address
  output logic [AXI4L_ADDR_BITS-1:0] m_axi4l_araddr,
  output logic [2:0]                 m_axi4l_arprot,
  output logic                       m_axi4l_arvalid,
  input  logic                       m_axi4l_arready,
  // AXI4-Lite read data
  input  logic [AXI4L_DATA_BITS-1:0] m_axi4l_rdata,
  input  logic [1:0]                 m_axi4l_rresp,
  input  logic                       m_axi4l_rvalid,
  output logic                       m_axi4l_rready,
  // debug
  output logic [2:0]                 o_dbg_state
);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [AXI4L_ADDR_BITS-1:0] r_addr;
  logic [AXI4L_DATA_BITS-1:0] r_wdata;
  logic [AXI4L_STRB_BITS-1:0] r_wstrb;
  logic [AXI4L_DATA_BITS-1:0] r_rdata;
  logic                       r_aw_done;
  logic                       r_w_done;

  logic w_req;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_in_ack;

  // Handshakes are decoded from state and the done flags rather than from the
  // valid outputs, which keeps the next-state logic free of output feedback.
  assign w_req    = (r_state == IDLE) & s_wb_stb_i;
  assign w_aw_hs  = (r_state == WRITE) & ~r_aw_done & m_axi4l_awready;
  assign w_w_hs   = (r_state == WRITE) & ~r_w_done  & m_axi4l_wready;
  assign w_b_hs   = (r_state == WRESP) & m_axi4l_bvalid;
  assign w_ar_hs  = (r_state == RADDR) & m_axi4l_arready;
  assign w_r_hs   = (r_state == RDATA) & m_axi4l_rvalid;
  assign w_in_ack = (r_state == ACK);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
    if (!m_axi4l_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and channel controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    m_axi4l_awvalid = 1'b0;
    m_axi4l_wvalid  = 1'b0;
    m_axi4l_bready  = 1'b0;
    m_axi4l_arvalid = 1'b0;
    m_axi4l_rready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_wb_stb_i) begin
          w_next_state = s_wb_we_i ? WRITE : RADDR;
        end
      end
      WRITE: begin
        // AW and W complete independently; leave once both have transferred,
        // counting a transfer happening on this very edge.
        m_axi4l_awvalid = ~r_aw_done;
        m_axi4l_wvalid  = ~r_w_done;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_next_state = WRESP;
        end
      end
      WRESP: begin
        m_axi4l_bready = 1'b1;
        if (m_axi4l_bvalid) begin
          w_next_state = ACK;
        end
      end
      RADDR: begin
        m_axi4l_arvalid = 1'b1;
        if (m_axi4l_arready) begin
          w_next_state = RDATA;
        end
      end
      RDATA: begin
        m_axi4l_rready = 1'b1;
        if (m_axi4l_rvalid) begin
          w_next_state = ACK;
        end
      end
      ACK: begin
        // A strobe still high here belongs to the cycle just acknowledged.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, channel progress flags and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
    if (!m_axi4l_aresetn) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_req) begin
        r_addr    <= AXI4L_ADDR_BITS'(s_wb_adr_i) << AXI4L_DATA_SIZE;
        r_wdata   <= s_wb_dat_i;
        r_wstrb   <= s_wb_sel_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      // Read data is kept until the next read completes; writes leave it alone.
      if (w_r_hs) begin
        r_rdata <= m_axi4l_rdata;
      end
    end
  end

`ifdef WISHBONE_TO_AXI4L_ERR_EN
  logic r_err;

  always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
    if (!m_axi4l_aresetn) begin
      r_err <= 1'b0;
    end else if (w_b_hs) begin
      r_err <= (m_axi4l_bresp != AXI_RESP_OKAY);
    end else if (w_r_hs) begin
      r_err <= (m_axi4l_rresp != AXI_RESP_OKAY);
    end
  end

  assign s_wb_ack_o = w_in_ack & ~r_err;
  assign s_wb_err_o = w_in_ack &  r_err;
`else
  // Response codes are deliberately dropped in this build.
  logic [3:0] w_unused_resp;
  assign w_unused_resp = {m_axi4l_bresp, m_axi4l_rresp};
  assign s_wb_ack_o    = w_in_ack;
`endif

  assign s_wb_dat_o     = r_rdata;
  assign m_axi4l_awaddr = r_addr;
  assign m_axi4l_awprot = AXI4L_PROT;
  assign m_axi4l_wdata  = r_wdata;
  assign m_axi4l_wstrb  = r_wstrb;
  assign m_axi4l_araddr = r_addr;
  assign m_axi4l_arprot = AXI4L_PROT;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_wishbone_to_axi4l.sv
// -----------------------------------------------------------------------------
// tb_wishbone_to_axi4l
//   Directed bench for wishbone_to_axi4l (default parameters, 64-bit data,
//   40-bit address). Define WISHBONE_TO_AXI4L_ERR_EN for both files to cover
//   the error-response build.
// -----------------------------------------------------------------------------
module tb_wishbone_to_axi4l;

`ifdef WISHBONE_TO_AXI4L_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int BUDGET = 100;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [36:0] wb_adr = '0;
  logic [63:0] wb_dat_i = '0;
  logic [63:0] wb_dat_o;
  logic [7:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_ack;
  logic        wb_err;

  logic [39:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [39:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [2:0]  dbg_state;

`ifndef WISHBONE_TO_AXI4L_ERR_EN
  assign wb_err = 1'b0;
`endif

  wishbone_to_axi4l dut (
    .m_axi4l_aresetn (rst_n),
    .m_axi4l_aclk    (clk),
    .s_wb_adr_i      (wb_adr),
    .s_wb_dat_i      (wb_dat_i),
    .s_wb_dat_o      (wb_dat_o),
    .s_wb_sel_i      (wb_sel),
    .s_wb_we_i       (wb_we),
    .s_wb_stb_i      (wb_stb),
    .s_wb_ack_o      (wb_ack),
`ifdef WISHBONE_TO_AXI4L_ERR_EN
    .s_wb_err_o      (wb_err),
`endif
    .m_axi4l_awaddr  (awaddr),
    .m_axi4l_awprot  (awprot),
    .m_axi4l_awvalid (awvalid),
    .m_axi4l_awready (awready),
    .m_axi4l_wdata   (wdata),
    .m_axi4l_wstrb   (wstrb),
    .m_axi4l_wvalid  (wvalid),
    .m_axi4l_wready  (wready),
    .m_axi4l_bresp   (bresp),
    .m_axi4l_bvalid  (bvalid),
    .m_axi4l_bready  (bready),
    .m_axi4l_araddr  (araddr),
    .m_axi4l_arprot  (arprot),
    .m_axi4l_arvalid (arvalid),
    .m_axi4l_arready (arready),
    .m_axi4l_rdata   (rdata),
    .m_axi4l_rresp   (rresp),
    .m_axi4l_rvalid  (rvalid),
    .m_axi4l_rready  (rready),
    .o_dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        we;
    logic [36:0] adr;
    logic [63:0] dat;
    logic [7:0]  sel;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic [39:0] exp_addr;
    int          exp_lat;   // negedges from driving stb to seeing ack
  } vec_t;

  vec_t vecs[8];
  vec_t cfg;

  // ---------------------------------------------------------------------------
  // scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int n_ack = 0;
  int n_err = 0;
  int n_bready_early = 0;
  logic [63:0] last_rd = '0;   // model of s_wb_dat_o
  int exp_acks = 0;
  int exp_errs = 0;

  // slave model state
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit sl_aw_done, sl_w_done, sl_ar_done, b_sent, r_sent, b_fire, r_fire;
  int n_aw, n_w, n_b, n_ar, n_r;
  logic [39:0] seen_awaddr, seen_araddr;
  logic [2:0]  seen_awprot, seen_arprot;
  logic [63:0] seen_wdata;
  logic [7:0]  seen_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit resp_is_err(input logic [1:0] r);
    return ERR_EN && (r != 2'b00);
  endfunction

  task automatic slave_reset();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    sl_aw_done = 0; sl_w_done = 0; sl_ar_done = 0;
    b_sent = 0; r_sent = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    seen_awaddr = '0; seen_araddr = '0; seen_awprot = '0; seen_arprot = '0;
    seen_wdata = '0; seen_wstrb = '0;
  endtask

  task automatic slave_hard_reset();
    slave_reset();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    b_fire = 0; r_fire = 0;
  endtask

  // One step of the AXI slave, run at each negedge. Ready/valid are driven
  // here and hold through the following posedge, so a high/high pair seen now
  // is a transfer on the next edge. B/R run first so they only react to
  // address/data transfers from earlier cycles.
  task automatic slave_step();
    if (b_fire) begin
      bvalid = 0; b_fire = 0;
    end else if (!bvalid && !b_sent && sl_aw_done && sl_w_done) begin
      if (b_cnt >= cfg.b_dly) begin bvalid = 1; bresp = cfg.resp; b_sent = 1; end
      else b_cnt++;
    end
    if (bvalid && bready && !b_fire) begin b_fire = 1; n_b++; end

    if (r_fire) begin
      rvalid = 0; r_fire = 0;
    end else if (!rvalid && !r_sent && sl_ar_done) begin
      if (r_cnt >= cfg.r_dly) begin
        rvalid = 1; rdata = cfg.rdata; rresp = cfg.resp; r_sent = 1;
      end else r_cnt++;
    end
    if (rvalid && rready && !r_fire) begin r_fire = 1; n_r++; end

    if (awready) awready = 0;
    else if (awvalid) begin
      if (aw_cnt >= cfg.aw_dly) begin
        awready = 1; sl_aw_done = 1; n_aw++;
        seen_awaddr = awaddr; seen_awprot = awprot;
      end else aw_cnt++;
    end

    if (wready) wready = 0;
    else if (wvalid) begin
      if (w_cnt >= cfg.w_dly) begin
        wready = 1; sl_w_done = 1; n_w++;
        seen_wdata = wdata; seen_wstrb = wstrb;
      end else w_cnt++;
    end

    if (arready) arready = 0;
    else if (arvalid) begin
      if (ar_cnt >= cfg.ar_dly) begin
        arready = 1; sl_ar_done = 1; n_ar++;
        seen_araddr = araddr; seen_arprot = arprot;
      end else ar_cnt++;
    end
  endtask

  // Every wait in the bench goes through here, once per clock.
  task automatic tick();
    @(negedge clk);
    if (wb_ack) n_ack++;
    if (wb_err) n_err++;
    if (bready && !(sl_aw_done && sl_w_done)) n_bready_early++;
    slave_step();
  endtask

  // ---------------------------------------------------------------------------
  // driver: one Wishbone cycle; called at a negedge
  // ---------------------------------------------------------------------------
  task automatic run_txn(input vec_t v, input bit keep_stb,
                         output int lat, output bit got_ack, output bit got_err);
    bit scrambled;
    cfg = v;
    slave_reset();
    wb_stb = 1; wb_we = v.we; wb_adr = v.adr; wb_dat_i = v.dat; wb_sel = v.sel;
    lat = 0; got_ack = 0; got_err = 0; scrambled = 0;
    while (lat < BUDGET) begin
      tick();
      lat++;
      // Request is captured by now; later input changes must not leak through.
      if (!scrambled && (awvalid || arvalid)) begin
        wb_adr = ~wb_adr; wb_dat_i = ~wb_dat_i; wb_sel = ~wb_sel; scrambled = 1;
      end
      if (wb_ack || wb_err) begin
        got_ack = wb_ack; got_err = wb_err;
        break;
      end
    end
    if (!keep_stb) wb_stb = 0;
    check({v.name, " done"}, 64'(got_ack | got_err), 64'd1);
  endtask

  task automatic check_txn(input vec_t v, input int lat, input bit got_ack, input bit got_err);
    bit e;
    e = resp_is_err(v.resp);
    if (e) exp_errs++; else exp_acks++;
    check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, " ack"}, 64'(got_ack), 64'(!e));
    check({v.name, " err"}, 64'(got_err), 64'(e));
    if (v.we) begin
      check({v.name, " n_aw"}, 64'(n_aw), 64'd1);
      check({v.name, " n_w"}, 64'(n_w), 64'd1);
      check({v.name, " n_b"}, 64'(n_b), 64'd1);
      check({v.name, " n_ar"}, 64'(n_ar), 64'd0);
      check({v.name, " awaddr"}, 64'(seen_awaddr), 64'(v.exp_addr));
      check({v.name, " awprot"}, 64'(seen_awprot), 64'd0);
      check({v.name, " wdata"}, seen_wdata, v.dat);
      check({v.name, " wstrb"}, 64'(seen_wstrb), 64'(v.sel));
    end else begin
      last_rd = v.rdata;
      check({v.name, " n_ar"}, 64'(n_ar), 64'd1);
      check({v.name, " n_r"}, 64'(n_r), 64'd1);
      check({v.name, " n_aw"}, 64'(n_aw), 64'd0);
      check({v.name, " araddr"}, 64'(seen_araddr), 64'(v.exp_addr));
      check({v.name, " arprot"}, 64'(seen_arprot), 64'd0);
    end
    check({v.name, " dat_o"}, wb_dat_o, last_rd);
  endtask

  // ---------------------------------------------------------------------------
  // test
  // ---------------------------------------------------------------------------
  initial begin
    int   lat;
    bit   ga, ge;
    int   acks_before;
    vec_t va, vb, vr;

    //               name          we    adr              dat                     sel    aw w  b  ar r  resp   rdata                   exp_addr          lat
    vecs[0] = '{"wr_basic",  1'b1, 37'h10,          64'h1122334455667788, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 64'h0,                  40'h80,           3};
    vecs[1] = '{"rd_delay",  1'b0, 37'h3,           64'h0,                8'hFF, 0, 0, 0, 4, 2, 2'b00, 64'h00000000DEADBEEF,    40'h18,           9};
    vecs[2] = '{"wr_w_1st",  1'b1, 37'h1,           64'hA5A5A5A55A5A5A5A, 8'h0F, 5, 0, 0, 0, 0, 2'b00, 64'h0,                  40'h8,            8};
    vecs[3] = '{"wr_aw_1st", 1'b1, 37'h1FFFFFFFFF,  64'h0F1E2D3C4B5A6978, 8'hAA, 0, 5, 2, 0, 0, 2'b00, 64'h0,                  40'hFFFFFFFFF8,  10};
    vecs[4] = '{"wr_slverr", 1'b1, 37'h4,           64'h0,                8'h01, 0, 0, 0, 0, 0, 2'b10, 64'h0,                  40'h20,           3};
    vecs[5] = '{"rd_decerr", 1'b0, 37'h0,           64'h0,                8'hFF, 0, 0, 0, 0, 0, 2'b11, 64'h0123456789ABCDEF,    40'h0,            3};
    vecs[6] = '{"wr_same",   1'b1, 37'h7,           64'hFFFFFFFFFFFFFFFF, 8'h80, 1, 1, 0, 0, 0, 2'b00, 64'h0,                  40'h38,           4};
    vecs[7] = '{"rd_rdly",   1'b0, 37'h2,           64'h0,                8'hFF, 0, 0, 0, 0, 3, 2'b00, 64'h55AA55AA33CC33CC,    40'h10,           6};

    cfg = vecs[0];
    slave_hard_reset();
    b_fire = 0; r_fire = 0;
    repeat (3) tick();

    // reset state
    check("rst awvalid", 64'(awvalid), 64'd0);
    check("rst wvalid", 64'(wvalid), 64'd0);
    check("rst arvalid", 64'(arvalid), 64'd0);
    check("rst bready", 64'(bready), 64'd0);
    check("rst rready", 64'(rready), 64'd0);
    check("rst ack", 64'(wb_ack), 64'd0);
    check("rst dat_o", wb_dat_o, 64'd0);
    check("rst awaddr", 64'(awaddr), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    rst_n = 1;
    tick();

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], 1'b0, lat, ga, ge);
      check_txn(vecs[i], lat, ga, ge);
      tick();
      check({vecs[i].name, " pulse_end"}, 64'({wb_ack, wb_err}), 64'd0);
    end

    // back-to-back write then read, stb held across the first ack
    va = '{"b2b_wr", 1'b1, 37'h20, 64'h00000000CAFEBABE, 8'hF0, 0, 0, 0, 0, 0, 2'b00, 64'h0, 40'h100, 3};
    vb = '{"b2b_rd", 1'b0, 37'h21, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 64'h13579BDF2468ACE0, 40'h108, 4};
    acks_before = n_ack;
    run_txn(va, 1'b1, lat, ga, ge);
    check_txn(va, lat, ga, ge);
    run_txn(vb, 1'b0, lat, ga, ge);
    check_txn(vb, lat, ga, ge);
    tick();
    check("b2b acks", 64'(n_ack - acks_before), 64'd2);

    // reset while waiting in RDATA
    vr = '{"rst_rd", 1'b0, 37'h5, 64'h0, 8'hFF, 0, 0, 0, 0, 40, 2'b00, 64'hFFFF0000FFFF0000, 40'h28, 0};
    cfg = vr;
    slave_reset();
    wb_stb = 1; wb_we = 0; wb_adr = vr.adr;
    lat = 0;
    while (!rready && lat < 20) begin
      tick();
      lat++;
    end
    check("mid_rst reached RDATA", 64'(rready), 64'd1);
    acks_before = n_ack;
    rst_n = 0;
    #1;
    check("mid_rst arvalid", 64'(arvalid), 64'd0);
    check("mid_rst rready", 64'(rready), 64'd0);
    check("mid_rst awvalid", 64'(awvalid), 64'd0);
    check("mid_rst wvalid", 64'(wvalid), 64'd0);
    check("mid_rst bready", 64'(bready), 64'd0);
    check("mid_rst ack", 64'({wb_ack, wb_err}), 64'd0);
    wb_stb = 0;
    slave_hard_reset();
    last_rd = '0;
    tick();
    tick();
    rst_n = 1;
    tick();
    check("mid_rst no ack", 64'(n_ack - acks_before), 64'd0);
    check("mid_rst dat_o", wb_dat_o, 64'd0);
    vr = '{"post_rst_rd", 1'b0, 37'h6, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 64'h2468ACE013579BDF, 40'h30, 3};
    run_txn(vr, 1'b0, lat, ga, ge);
    check_txn(vr, lat, ga, ge);
    tick();

    // totals
    check("total acks", 64'(n_ack), 64'(exp_acks));
    check("total errs", 64'(n_err), 64'(exp_errs));
    check("bready early", 64'(n_bready_early), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_to_axi4l.md
Name: wishbone_to_axi4l

Overview:
Bridges a single-clock Wishbone classic slave port to an AXI4-Lite master port, so Wishbone-side controllers (SPU sequencers, test masters) can drive AXI4-Lite register spaces. One outstanding transaction at a time. Each Wishbone cycle becomes exactly one AXI4-Lite write (AW+W→B) or read (AR→R). The Wishbone ack is returned only after the AXI response.

Parameters:
AXI4L_ADDR_BITS, 40, AXI4-Lite byte address width
AXI4L_DATA_SIZE, 3, log2 of data bytes (0:8bit, 1:16bit, 2:32bit, 3:64bit)
AXI4L_DATA_BITS, 8 << AXI4L_DATA_SIZE, derived data width
AXI4L_STRB_BITS, AXI4L_DATA_BITS/8, derived strobe width
WB_ADR_BITS, AXI4L_ADDR_BITS - AXI4L_DATA_SIZE, derived word address width
AXI4L_PROT, 3'b000, constant driven on awprot/arprot

Ports:
m_axi4l_aresetn  in  1  asynchronous active-low reset
m_axi4l_aclk  in  1  single clock for both sides
s_wb_adr_i  in  WB_ADR_BITS  word address
s_wb_dat_i  in  AXI4L_DATA_BITS  write data
s_wb_dat_o  out  AXI4L_DATA_BITS  read data, valid with ack
s_wb_sel_i  in  AXI4L_STRB_BITS  byte select
s_wb_we_i  in  1  1=write
s_wb_stb_i  in  1  strobe, held until ack
s_wb_ack_o  out  1  one-cycle completion pulse
m_axi4l_awaddr/awprot/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp in [1:0], bvalid in, bready out; araddr/arprot/arvalid out, arready in; rdata in, rresp in [1:0], rvalid in, rready out

Behaviour:
- Reset (async assert, sync release): every valid/ready out = 0, s_wb_ack_o = 0, s_wb_dat_o = 0, addr/data regs = 0, state IDLE. Reset mid-transaction drops the transaction silently; no ack.
- Address: axaddr = {s_wb_adr_i, AXI4L_DATA_SIZE'b0}, captured in IDLE. wdata = s_wb_dat_i, wstrb = s_wb_sel_i, also captured.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, ACK.
- IDLE: stb & we → WRITE, awvalid=wvalid=1 next cycle. stb & !we → RADDR, arvalid=1 next cycle.
- WRITE: awvalid drops on its own aw handshake and wvalid on its own w handshake, independently, in either order or the same cycle. When both are done → WRESP with bready=1.
- WRESP: bvalid → ack next cycle (state ACK). bready=0 except in WRESP.
- RADDR: arvalid held until arready, then RDATA with rready=1. RDATA: rvalid → s_wb_dat_o <= rdata, ack next cycle.
- ACK: s_wb_ack_o=1 for exactly this cycle. Return to IDLE. Stb still high this cycle is not a new request.
- Minimum latency, zero-wait AXI slave: stb at cycle 0, valid cycle 1, B/R cycle 2, ack cycle 3. Back-to-back: next request accepted in the IDLE cycle after ACK.
- Valid signals never drop without a handshake. Payload stable while valid. Request fields captured, so s_wb_* changes after IDLE have no effect.
- s_wb_dat_o holds the last read data until the next read completes. It is not cleared after writes.
- bresp/rresp are ignored unless the optional feature is enabled.

Optional Feature:
Macro WISHBONE_TO_AXI4L_ERR_EN.
- With: extra port s_wb_err_o out 1 (reset 0). If bresp or rresp is not 2'b00, s_wb_err_o pulses instead of s_wb_ack_o in the ACK cycle; read data is still loaded.
- Without: port absent; ack always pulses; response codes discarded.

Decomposition:
- Package wishbone_to_axi4l_pkg: state enum (IDLE, WRITE, WRESP, RADDR, RDATA, ACK) and AXI resp constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11).
- No sub-module: one FSM with aw_done/w_done flags fits in about 200 lines.

Test Plan:
- Write adr=0x10, dat=0x1122334455667788, sel=0xFF, zero-wait slave → awaddr=0x80, wstrb=0xFF, single ack at cycle 3.
- Read adr=0x3, slave returns rdata=0xDEADBEEF after arready delay 4 and rvalid delay 2 → araddr=0x18, dat_o=0xDEADBEEF at ack, exactly one ack.
- Write with wready 5 cycles before awready, then the reverse order → each channel handshakes once, bready only after both, ack after B.
- Back-to-back write then read with stb held high across ack → exactly two AXI transactions and two acks, none duplicated.
- Assert aresetn low while in RDATA → all valids/ready and ack go 0 immediately. After release, a new read completes normally.
- With WISHBONE_TO_AXI4L_ERR_EN, bresp=2'b10 → s_wb_err_o=1 and ack=0 for one cycle. Without the macro, the same stimulus gives ack=1.
